// File: rtl/ck_sync_fifo_if.sv
// Producer/consumer bundle for ck_sync_fifo; master drives requests, slave is the FIFO.
interface ck_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic [DATA_W-1:0] dataIn;
  logic              push;
  logic              pop;
  logic              clrErr;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              full;
  logic              almostFull;
  logic              empty;
  logic              almostEmpty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output dataIn, push, pop, clrErr,
    input  dataOut, dataValid, full, almostFull, empty, almostEmpty, count, overflow, underflow
  );

  modport slave (
    input  dataIn, push, pop, clrErr,
    output dataOut, dataValid, full, almostFull, empty, almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/ck_sync_fifo.sv
// Single-clock FIFO with level flags, occupancy count and sticky error flags; read latency 1 (FWFT=0) or 0 (FWFT=1).
// Full FIFO rejects push, empty FIFO rejects pop; rejections set sticky overflow/underflow.
module ck_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic           ck,
  input  logic           rst,
  ck_sync_fifo_if.slave  bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_push_acc;
  logic w_pop_acc;

  // Acceptance looks only at registered occupancy, so a pop never makes room for a same-cycle push.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_acc = bus.push & ~w_full;
  assign w_pop_acc  = bus.pop & ~w_empty;

  always_ff @(posedge ck) begin
    if (!rst && w_push_acc) begin
      r_mem[r_wr_ptr] <= bus.dataIn;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= (r_rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error event outranks a same-cycle clear.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.push && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.clrErr) begin
        r_ovf <= 1'b0;
      end
      if (bus.pop && w_empty) begin
        r_udf <= 1'b1;
      end else if (bus.clrErr) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostFull  = (r_count >= CNT_W'(AF_LVL));
  assign bus.almostEmpty = (r_count <= CNT_W'(AE_LVL));
  assign bus.count       = r_count;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_udf;

  if (FWFT == 0) begin : g_reg_rd
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_vld;

    always_ff @(posedge ck) begin
      if (rst) begin
        r_data_out <= '0;
        r_data_vld <= 1'b0;
      end else begin
        r_data_vld <= w_pop_acc;
        if (w_pop_acc) begin
          r_data_out <= r_mem[r_rd_ptr];
        end
      end
    end

    assign bus.dataOut   = r_data_out;
    assign bus.dataValid = r_data_vld;
  end else begin : g_fwft
    // Head word is presented straight from storage; pop acknowledges it.
    assign bus.dataOut   = r_mem[r_rd_ptr];
    assign bus.dataValid = ~w_empty;
  end

endmodule

// File: tb/tb_ck_sync_fifo.sv
// Directed bench: three FIFO instances (16-deep registered, 16-deep FWFT, 5-deep registered).
module tb_ck_sync_fifo;

  logic ck = 1'b0;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 ck = ~ck;

  ck_sync_fifo_if #(.DATA_W(8), .CNT_W(5)) ifa ();
  ck_sync_fifo_if #(.DATA_W(8), .CNT_W(5)) ifb ();
  ck_sync_fifo_if #(.DATA_W(8), .CNT_W(3)) ifc ();

  ck_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(12), .AE_LVL(2), .FWFT(0)) u_fifo_a (
    .ck(ck), .rst(rst_a), .bus(ifa.slave));
  ck_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(12), .AE_LVL(2), .FWFT(1)) u_fifo_b (
    .ck(ck), .rst(rst_b), .bus(ifb.slave));
  ck_sync_fifo #(.DATA_W(8), .DEPTH(5), .AF_LVL(5), .AE_LVL(0), .FWFT(0)) u_fifo_c (
    .ck(ck), .rst(rst_c), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step_a(input logic ps, input logic pp, input logic cl, input logic [7:0] d);
    ifa.push = ps; ifa.pop = pp; ifa.clrErr = cl; ifa.dataIn = d;
    @(posedge ck); #1;
    ifa.push = 1'b0; ifa.pop = 1'b0; ifa.clrErr = 1'b0;
  endtask

  task automatic step_b(input logic ps, input logic pp, input logic [7:0] d);
    ifb.push = ps; ifb.pop = pp; ifb.clrErr = 1'b0; ifb.dataIn = d;
    @(posedge ck); #1;
    ifb.push = 1'b0; ifb.pop = 1'b0;
  endtask

  task automatic step_c(input logic ps, input logic pp, input logic [7:0] d);
    ifc.push = ps; ifc.pop = pp; ifc.clrErr = 1'b0; ifc.dataIn = d;
    @(posedge ck); #1;
    ifc.push = 1'b0; ifc.pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp4 [5];
    logic [7:0] q [$];
    logic [7:0] d;
    logic [7:0] e;
    logic       ps;
    logic       pp;
    int         npush;
    int         j;

    exp4 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h33};
    ifa.push = 1'b0; ifa.pop = 1'b0; ifa.clrErr = 1'b0; ifa.dataIn = 8'h00;
    ifb.push = 1'b0; ifb.pop = 1'b0; ifb.clrErr = 1'b0; ifb.dataIn = 8'h00;
    ifc.push = 1'b0; ifc.pop = 1'b0; ifc.clrErr = 1'b0; ifc.dataIn = 8'h00;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(posedge ck); #1;
    @(posedge ck); #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state
    chk("rst_cnt",   32'(ifa.count), 0);
    chk("rst_empty", 32'(ifa.empty), 1);
    chk("rst_ae",    32'(ifa.almostEmpty), 1);
    chk("rst_af",    32'(ifa.almostFull), 0);
    chk("rst_full",  32'(ifa.full), 0);
    chk("rst_dv",    32'(ifa.dataValid), 0);
    chk("rst_dout",  32'(ifa.dataOut), 0);
    chk("rst_ovf",   32'(ifa.overflow), 0);
    chk("rst_udf",   32'(ifa.underflow), 0);

    // Fill to full, then one rejected push
    for (int i = 0; i < 16; i++) begin
      step_a(1'b1, 1'b0, 1'b0, 8'(i));
      chk("fill_cnt",  32'(ifa.count), i + 1);
      chk("fill_af",   32'(ifa.almostFull), (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", 32'(ifa.full), (i == 15) ? 1 : 0);
    end
    chk("fill_ovf", 32'(ifa.overflow), 0);
    step_a(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_set", 32'(ifa.overflow), 1);
    chk("ovf_cnt", 32'(ifa.count), 16);

    // Drain in order, then one rejected pop
    for (int i = 0; i < 16; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_dv",   32'(ifa.dataValid), 1);
      chk("drain_dout", 32'(ifa.dataOut), i);
      chk("drain_cnt",  32'(ifa.count), 15 - i);
    end
    chk("drain_empty", 32'(ifa.empty), 1);
    chk("drain_ae",    32'(ifa.almostEmpty), 1);
    step_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk("udf_set",  32'(ifa.underflow), 1);
    chk("udf_dv",   32'(ifa.dataValid), 0);
    chk("udf_hold", 32'(ifa.dataOut), 8'h0F);

    step_a(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_ovf", 32'(ifa.overflow), 0);
    chk("clr_udf", 32'(ifa.underflow), 0);

    // Push+pop at count 5
    for (int i = 1; i <= 5; i++) step_a(1'b1, 1'b0, 1'b0, 8'(i));
    step_a(1'b1, 1'b1, 1'b0, 8'h33);
    chk("pp5_cnt",  32'(ifa.count), 5);
    chk("pp5_dout", 32'(ifa.dataOut), 8'h01);
    chk("pp5_dv",   32'(ifa.dataValid), 1);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 8'h00);
      chk("pp5_order", 32'(ifa.dataOut), 32'(exp4[i]));
    end
    chk("pp5_end_cnt", 32'(ifa.count), 0);

    // Push+pop while empty
    step_a(1'b1, 1'b1, 1'b0, 8'h44);
    chk("ppe_cnt", 32'(ifa.count), 1);
    chk("ppe_udf", 32'(ifa.underflow), 1);
    chk("ppe_dv",  32'(ifa.dataValid), 0);
    step_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ppe_dout", 32'(ifa.dataOut), 8'h44);
    step_a(1'b0, 1'b0, 1'b1, 8'h00);

    // Push+pop while full
    for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 1'b0, 8'(128 + i));
    step_a(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("ppf_cnt",  32'(ifa.count), 15);
    chk("ppf_ovf",  32'(ifa.overflow), 1);
    chk("ppf_dout", 32'(ifa.dataOut), 8'h80);
    chk("ppf_full", 32'(ifa.full), 0);
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 8'h00);
      chk("ppf_drain", 32'(ifa.dataOut), 128 + i);
    end
    chk("mid_cnt", 32'(ifa.count), 7);
    chk("mid_ovf", 32'(ifa.overflow), 1);

    // Reset mid-operation overrides a concurrent push
    rst_a = 1'b1;
    step_a(1'b1, 1'b0, 1'b0, 8'h99);
    rst_a = 1'b0;
    chk("mrst_cnt",   32'(ifa.count), 0);
    chk("mrst_empty", 32'(ifa.empty), 1);
    chk("mrst_ovf",   32'(ifa.overflow), 0);
    chk("mrst_dv",    32'(ifa.dataValid), 0);
    step_a(1'b1, 1'b0, 1'b0, 8'h11);
    step_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk("mrst_dout", 32'(ifa.dataOut), 8'h11);
    chk("mrst_dv1",  32'(ifa.dataValid), 1);

    // Error set wins over same-cycle clear
    for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 1'b0, 8'(i));
    step_a(1'b1, 1'b0, 1'b1, 8'h55);
    chk("setwin_ovf", 32'(ifa.overflow), 1);
    step_a(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr2_ovf", 32'(ifa.overflow), 0);

    // FWFT instance
    chk("fw_rst_dv",    32'(ifb.dataValid), 0);
    chk("fw_rst_empty", 32'(ifb.empty), 1);
    step_b(1'b1, 1'b0, 8'h5A);
    chk("fw_dout", 32'(ifb.dataOut), 8'h5A);
    chk("fw_dv",   32'(ifb.dataValid), 1);
    step_b(1'b0, 1'b1, 8'h00);
    chk("fw_pop_dv",    32'(ifb.dataValid), 0);
    chk("fw_pop_empty", 32'(ifb.empty), 1);
    step_b(1'b1, 1'b0, 8'h10);
    step_b(1'b1, 1'b0, 8'h20);
    step_b(1'b1, 1'b0, 8'h30);
    chk("fw_head", 32'(ifb.dataOut), 8'h10);
    chk("fw_cnt3", 32'(ifb.count), 3);
    step_b(1'b0, 1'b1, 8'h00);
    chk("fw_head2", 32'(ifb.dataOut), 8'h20);
    step_b(1'b0, 1'b1, 8'h00);
    chk("fw_head3", 32'(ifb.dataOut), 8'h30);
    step_b(1'b0, 1'b1, 8'h00);
    chk("fw_last_dv", 32'(ifb.dataValid), 0);

    // Depth-5 wrap: push,push,push+pop,pop,pop keeps count in 1..4
    npush = 1;
    d = 8'h01;
    step_c(1'b1, 1'b0, d);
    q.push_back(d);
    j = 0;
    while (npush < 23) begin
      ps = (j % 5 < 3) ? 1'b1 : 1'b0;
      pp = (j % 5 >= 2) ? 1'b1 : 1'b0;
      d  = 8'(npush * 13 + 1);
      step_c(ps, pp, d);
      if (pp) begin
        e = q.pop_front();
        chk("wrap_dout", 32'(ifc.dataOut), 32'(e));
        chk("wrap_dv",   32'(ifc.dataValid), 1);
      end
      if (ps) begin
        q.push_back(d);
        npush++;
      end
      chk("wrap_cnt",   32'(ifc.count), q.size());
      chk("wrap_flags", 32'({ifc.full, ifc.almostFull, ifc.empty, ifc.almostEmpty,
                             ifc.overflow, ifc.underflow}), 0);
      j++;
    end
    while (q.size() > 0) begin
      step_c(1'b0, 1'b1, 8'h00);
      e = q.pop_front();
      chk("wrap_tail", 32'(ifc.dataOut), 32'(e));
    end
    chk("wrap_empty", 32'(ifc.empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ck_sync_fifo.md
Name: ck_sync_fifo

Overview:
Parametrised single-clock FIFO, the successor to the clock-crossing FIFO skeleton. It adds configurable depth, almost-full and almost-empty thresholds, a live occupancy count, and sticky overflow/underflow error flags. A selectable read mode offers either a registered read or first-word-fall-through (FWFT). It buffers data between producer and consumer logic inside a single clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; need not be a power of two)
AF_LVL, 12, almostFull asserts when count >= AF_LVL (1..DEPTH)
AE_LVL, 2, almostEmpty asserts when count <= AE_LVL (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
Derived: ADDR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)

Ports:
ck  in  1  clock, all logic on the rising edge
rst  in  1  synchronous active-high reset
dataIn  in  DATA_W  write data
push  in  1  write request
pop  in  1  read request
dataOut  out  DATA_W  read data
dataValid  out  1  dataOut holds valid data (meaning depends on FWFT)
full  out  1  count == DEPTH
almostFull  out  1  count >= AF_LVL
empty  out  1  count == 0
almostEmpty  out  1  count <= AE_LVL
count  out  CNT_W  current occupancy
overflow  out  1  sticky: a push was rejected because the FIFO was full
underflow  out  1  sticky: a pop was rejected because the FIFO was empty
clrErr  in  1  clears overflow and underflow

Behaviour:
- Reset (rst=1 at a clock edge): write and read pointers = 0, count = 0, dataOut = 0, dataValid = 0, overflow = 0, underflow = 0.
  - Resulting flags: full = 0, empty = 1, almostEmpty = 1, almostFull = 0 (AF_LVL >= 1).
  - Reset overrides every other input; any operation in flight is discarded.
  - Memory contents are not reset.
- Acceptance is evaluated only against registered state:
  - pushAcc = push & !full
  - popAcc = pop & !empty
  - A pop does not free space for a same-cycle push. When full, push+pop accepts the pop only; the push is rejected and sets overflow.
- Write: on pushAcc, mem[wrPtr] <= dataIn. wrPtr increments and wraps from DEPTH-1 to 0.
- Read: on popAcc, rdPtr increments and wraps from DEPTH-1 to 0.
- Count update:
  - +1 on pushAcc only.
  - -1 on popAcc only.
  - Unchanged when both or neither are accepted.
  - count never exceeds DEPTH and never goes below 0.
- Flags: full, empty, almostFull and almostEmpty are combinational decodes of the registered count. They update in the cycle after the causing edge and never glitch within a cycle.
- Simultaneous push and pop while empty: the push is accepted; the pop is rejected and sets underflow. count becomes 1.
- Errors:
  - overflow <= 1 on push & full.
  - underflow <= 1 on pop & empty.
  - clrErr=1 clears both. If an error event and clrErr occur in the same cycle, the set wins.
- FWFT=0 (registered read):
  - On popAcc, dataOut <= mem[rdPtr] and dataValid <= 1 in the next cycle (latency 1).
  - Without popAcc, dataValid <= 0 and dataOut holds its last value.
- FWFT=1 (first-word-fall-through):
  - dataOut = mem[rdPtr] and dataValid = !empty, both combinational from registered state.
  - pop acknowledges the presented word.
  - A word written into an empty FIFO appears on dataOut the cycle after its push edge.
- Pointer wrap must be correct for non-power-of-two DEPTH, with explicit compare against DEPTH-1.
- No internal state machine beyond the pointer and count registers; all outputs are registered or decoded from registers. No combinational path from push/pop to any output.

Test Plan:
1. Reset then fill: DEPTH=16, AF_LVL=12. Push 0x00..0x0F on 16 consecutive cycles -> almostFull rises after the 12th push, full and count=16 after the 16th, overflow=0. A 17th push (0xAA) -> overflow=1, count stays 16, 0xAA is never read.
2. Drain, FWFT=0: from full, pop on 16 consecutive cycles -> dataOut = 0x00..0x0F, each with dataValid one cycle after its pop. empty=1 and almostEmpty=1 at the end. A 17th pop -> underflow=1, dataValid=0.
3. FWFT=1, single word: push 0x5A into an empty FIFO -> next cycle dataOut=0x5A, dataValid=1. Pop -> following cycle dataValid=0, empty=1.
4. Simultaneous push and pop:
   - At count=5: push 0x33 with pop -> count stays 5, FIFO order preserved.
   - When full: push+pop -> count=15, overflow=1.
   - When empty: push+pop -> count=1, underflow=1.
5. Wrap with DEPTH=5 (non-power-of-two): interleave 23 pushes and pops keeping count between 1 and 4 -> read stream equals write stream, no flags asserted.
6. Reset mid-operation at count=7 with overflow=1 -> next cycle count=0, empty=1, overflow=0, dataValid=0. Then push 0x11 and pop -> 0x11 is returned. clrErr in the same cycle as an overflow event -> overflow=1.
